alu_ex_unit: RTL and testbench
==============================

Name: alu_ex_unit

Overview:
Parametrised execute-stage unit for the pipelined MIPS core. It combines ALU control decode (ALUOp + funct) and the single-cycle ALU with an iterative multi-cycle multiply/divide engine and HI/LO registers. It raises a stall to the hazard unit while a mult/div is running or while an mfhi/mflo would read stale HI/LO.

Parameters:
WIDTH, 32, datapath width in bits; must be a power of two, at least 8.
MD_ENABLE, 1, 1 = mult/div/mfhi/mflo implemented; 0 = those functs decode as illegal and never stall.
SHW, $clog2(WIDTH), shift-amount width (derived, do not override).

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high
valid  in  1  EX stage holds a live instruction
flush  in  1  synchronous abort of the mult/div in progress
alu_op  in  3  ALUOp from the main control unit
funct  in  6  instruction funct field
shamt  in  SHW  shift amount
a  in  WIDTH  operand rs
b  in  WIDTH  operand rt or immediate
result  out  WIDTH  combinational ALU result
zero  out  1  result == 0
overflow  out  1  signed overflow of add/sub/addi (trap-type ops only)
illegal  out  1  valid and undefined funct under ALUOp 010
stall  out  1  hold IF/ID/EX
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
md_busy  out  1  engine state is RUN

Behaviour:
- ALUOp decode: 000 add (lw/sw); 001 sub (beq/bne); 010 R-type by funct; 011 add with overflow check (addi); 100 and (andi); 101 or (ori); 110 slt (slti); 111 add, no overflow.
- R-type funct: 100000 add (ovf), 100001 addu, 100010 sub (ovf), 100011 subu, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt, 101011 sltu, 000000 sll, 000010 srl, 000011 sra (shift b by shamt), 011000 mult, 011001 multu, 011010 div, 011011 divu, 010000 mfhi, 010010 mflo. Any other funct: illegal=1 (gated by valid), result=0.
- result, zero, overflow and illegal are combinational and have 0-cycle latency. For mult/div, result=0. For mfhi/mflo, result=hi or lo.
- md_op = valid & MD_ENABLE & ALUOp 010 & funct in {mult, multu, div, divu}. rd_op is the same condition for mfhi/mflo.
- FSM IDLE/RUN/DONE; a counter of SHW+1 bits.
  - IDLE: if md_op, latch operand magnitudes, signs and op, clear the counter, go to RUN.
  - RUN: one shift-add (mult) or restoring-subtract (div) step per cycle, exactly WIDTH cycles. On the last step hi/lo are written at the clock edge and the FSM goes to DONE.
  - DONE: one cycle, then IDLE.
- Stall rule: stall = (state==IDLE & md_op) | (state==RUN) | (state==IDLE & rd_op & 0). This means mfhi/mflo stall only while RUN. stall is 0 in DONE, so the issuing instruction leaves EX at the DONE edge and is not restarted. A mult issued at cycle 0 gives stall high in cycles 0..WIDTH, and hi/lo are valid from cycle WIDTH+1.
- mult/multu: hi:lo = 2*WIDTH-bit product. In signed mode the product is computed on magnitudes and negated if the signs differ.
- div/divu: lo = quotient, hi = remainder. In signed mode the quotient sign is sign(a)^sign(b) and the remainder takes the sign of a.
- Divide by zero: lo = all ones, hi = a. No exception.
- Signed most-negative / -1: lo = most-negative, hi = 0.
- flush or reset in any state: return to IDLE next edge, counter cleared, hi/lo left unchanged by flush. Reset forces hi=lo=0.
- Reset values: hi=0, lo=0, md_busy=0, stall=0, FSM IDLE. Combinational outputs follow their inputs.
- md_op arriving in DONE is ignored. The pipeline guarantees EX changes at that edge.

Test Plan:
- ALUOp 010, funct 100010, a=5, b=7 -> result=0xFFFFFFFE, zero=0, overflow=0. With a=0x80000000, b=1 -> overflow=1.
- ALUOp 010, funct 000011, b=0x80000000, shamt=4 -> result=0xF8000000. Then funct 101011, a=1, b=0xFFFFFFFF -> result=1. Then funct 111111 -> illegal=1.
- mult, a=-3, b=7 -> stall high cycles 0..32, md_busy high cycles 1..32, then hi=0xFFFFFFFF, lo=0xFFFFFFEB. A following mflo gives result=0xFFFFFFEB.
- div, a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu, a=9, b=0 -> lo=0xFFFFFFFF, hi=9.
- Start multu, assert flush at RUN cycle 10 -> IDLE next cycle, stall=0, hi/lo retain their prior values. Reset mid-RUN -> hi=lo=0, md_busy=0.
- MD_ENABLE=0, WIDTH=16: mult -> illegal=1, stall never asserts. add of 0x7FFF+1 -> overflow=1.

Source files
------------

// File: rtl/alu_ex_unit_if.sv
// Execute-stage bus for alu_ex_unit: instruction operands in, ALU result,
// hazard stall and HI/LO state out.
interface alu_ex_unit_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             valid;
  logic             flush;
  logic [2:0]       alu_op;
  logic [5:0]       funct;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             illegal;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             md_busy;

  modport master (
    output valid, flush, alu_op, funct, shamt, a, b,
    input  result, zero, overflow, illegal, stall, hi, lo, md_busy
  );

  modport slave (
    input  valid, flush, alu_op, funct, shamt, a, b,
    output result, zero, overflow, illegal, stall, hi, lo, md_busy
  );
endinterface

// File: rtl/alu_ex_unit.sv
// MIPS execute stage: ALU control decode, single-cycle ALU and an iterative
// one-bit-per-cycle mult/div engine owning the HI/LO registers.
module alu_ex_unit #(
  parameter  int WIDTH     = 32,
  parameter  int MD_ENABLE = 1,
  localparam int SHW       = $clog2(WIDTH)
) (
  input logic         clk,
  input logic         reset,
  alu_ex_unit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam bit MD = (MD_ENABLE != 0);
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH - 1);

  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;

  state_t             r_state;
  logic [SHW:0]       r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opb;
  logic               r_op_div;
  logic               r_sign_a;
  logic               r_sign_b;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic               w_add_ovf;
  logic               w_sub_ovf;
  logic [WIDTH-1:0]   w_slt;
  logic [WIDTH-1:0]   w_sltu;
  logic [WIDTH-1:0]   w_result;
  logic               w_ovf;
  logic               w_undef;
  logic               w_md_funct;
  logic               w_md_op;

  assign w_sum     = bus.a + bus.b;
  assign w_diff    = bus.a - bus.b;
  assign w_add_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
  assign w_sub_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
  assign w_slt     = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
  assign w_sltu    = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    w_result   = '0;
    w_ovf      = 1'b0;
    w_undef    = 1'b0;
    w_md_funct = 1'b0;
    unique case (bus.alu_op)
      3'b000: w_result = w_sum;
      3'b001: w_result = w_diff;
      3'b011: begin
        w_result = w_sum;
        w_ovf    = w_add_ovf;
      end
      3'b100: w_result = bus.a & bus.b;
      3'b101: w_result = bus.a | bus.b;
      3'b110: w_result = w_slt;
      3'b111: w_result = w_sum;
      default: begin
        case (bus.funct)
          F_ADD: begin
            w_result = w_sum;
            w_ovf    = w_add_ovf;
          end
          F_ADDU: w_result = w_sum;
          F_SUB: begin
            w_result = w_diff;
            w_ovf    = w_sub_ovf;
          end
          F_SUBU: w_result = w_diff;
          F_AND:  w_result = bus.a & bus.b;
          F_OR:   w_result = bus.a | bus.b;
          F_XOR:  w_result = bus.a ^ bus.b;
          F_NOR:  w_result = ~(bus.a | bus.b);
          F_SLT:  w_result = w_slt;
          F_SLTU: w_result = w_sltu;
          F_SLL:  w_result = bus.b << bus.shamt;
          F_SRL:  w_result = bus.b >> bus.shamt;
          F_SRA:  w_result = $unsigned($signed(bus.b) >>> bus.shamt);
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            w_md_funct = MD;
            w_undef    = !MD;
          end
          F_MFHI: begin
            w_result = MD ? r_hi : '0;
            w_undef  = !MD;
          end
          F_MFLO: begin
            w_result = MD ? r_lo : '0;
            w_undef  = !MD;
          end
          default: w_undef = 1'b1;
        endcase
      end
    endcase
  end

  assign w_md_op = bus.valid && (bus.alu_op == 3'b010) && w_md_funct;

  // One engine step. Mult: acc = {partial, multiplier}, add then shift right.
  // Div: acc = {remainder, dividend/quotient}, restoring shift-subtract.
  logic [WIDTH:0]     w_madd;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_trial;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_hi_fin;
  logic [WIDTH-1:0]   w_lo_fin;

  assign w_madd     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_mul_next = {w_madd, r_acc[WIDTH-1:1]};
  assign w_shift    = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_trial    = w_shift - {1'b0, r_opb};
  assign w_div_next = w_trial[WIDTH] ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                     : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
  assign w_step     = r_op_div ? w_div_next : w_mul_next;

  // Signs were latched as zero for unsigned ops, so the fix-ups are no-ops there.
  assign w_prod   = (r_sign_a ^ r_sign_b) ? -w_step : w_step;
  assign w_quo    = w_step[WIDTH-1:0];
  assign w_rem    = w_step[2*WIDTH-1:WIDTH];
  assign w_lo_fin = !r_op_div ? w_prod[WIDTH-1:0]
                  : r_dbz     ? '1
                  : (r_sign_a ^ r_sign_b) ? -w_quo : w_quo;
  assign w_hi_fin = !r_op_div ? w_prod[2*WIDTH-1:WIDTH]
                  : r_sign_a  ? -w_rem : w_rem;

  logic             w_signed_op;
  logic             w_neg_a;
  logic             w_neg_b;

  assign w_signed_op = !bus.funct[0];
  assign w_neg_a     = w_signed_op && bus.a[WIDTH-1];
  assign w_neg_b     = w_signed_op && bus.b[WIDTH-1];

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_op_div <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_dbz    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else if (bus.flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_md_op) begin
            r_acc    <= {{WIDTH{1'b0}}, (w_neg_a ? -bus.a : bus.a)};
            r_opb    <= w_neg_b ? -bus.b : bus.b;
            r_op_div <= bus.funct[1];
            r_sign_a <= w_neg_a;
            r_sign_b <= w_neg_b;
            r_dbz    <= (bus.b == '0);
            r_cnt    <= '0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_hi    <= w_hi_fin;
            r_lo    <= w_lo_fin;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // mfhi/mflo only need to wait while RUN, which the RUN term already covers.
  assign bus.stall    = ((r_state == S_IDLE) && w_md_op) || (r_state == S_RUN);
  assign bus.md_busy  = (r_state == S_RUN);
  assign bus.result   = w_result;
  assign bus.zero     = (w_result == '0);
  assign bus.overflow = w_ovf;
  assign bus.illegal  = bus.valid && (bus.alu_op == 3'b010) && w_undef;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;

endmodule

// File: tb/tb_alu_ex_unit.sv
// Directed bench for alu_ex_unit: a 32-bit mult/div build and a 16-bit
// build without the mult/div engine.
module tb_alu_ex_unit;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  alu_ex_unit_if #(.WIDTH(32)) bus32 ();
  alu_ex_unit_if #(.WIDTH(16)) bus16 ();

  alu_ex_unit #(.WIDTH(32), .MD_ENABLE(1)) u_dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus32)
  );

  alu_ex_unit #(.WIDTH(16), .MD_ENABLE(0)) u_dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic v, input logic [2:0] op, input logic [5:0] fn,
                         input logic [31:0] av, input logic [31:0] bv, input logic [4:0] sh);
    bus32.valid  = v;
    bus32.alu_op = op;
    bus32.funct  = fn;
    bus32.a      = av;
    bus32.b      = bv;
    bus32.shamt  = sh;
    #1;
  endtask

  // Issue a mult/div, hold it through RUN, return in the DONE cycle.
  task automatic run_md(input logic [5:0] fn, input logic [31:0] av, input logic [31:0] bv);
    drive32(1'b1, 3'b010, fn, av, bv, 5'd0);
    repeat (33) tick();
    bus32.valid = 1'b0;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus32.flush = 1'b0;
    bus16.flush = 1'b0;
    drive32(1'b0, 3'b000, 6'd0, 32'd0, 32'd0, 5'd0);
    bus16.valid = 1'b0; bus16.alu_op = 3'b000; bus16.funct = 6'd0;
    bus16.a = 16'd0; bus16.b = 16'd0; bus16.shamt = 4'd0;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    check("rst_hi", bus32.hi, 0);
    check("rst_lo", bus32.lo, 0);
    check("rst_busy", bus32.md_busy, 0);
    check("rst_stall", bus32.stall, 0);

    // Single-cycle ALU
    drive32(1'b1, 3'b010, 6'b100010, 32'd5, 32'd7, 5'd0);
    check("sub_res", bus32.result, 32'hFFFF_FFFE);
    check("sub_zero", bus32.zero, 0);
    check("sub_ovf", bus32.overflow, 0);
    drive32(1'b1, 3'b010, 6'b100010, 32'h8000_0000, 32'd1, 5'd0);
    check("sub_ovf_hit", bus32.overflow, 1);
    drive32(1'b1, 3'b010, 6'b100011, 32'h8000_0000, 32'd1, 5'd0);
    check("subu_no_ovf", bus32.overflow, 0);
    drive32(1'b1, 3'b010, 6'b000011, 32'd0, 32'h8000_0000, 5'd4);
    check("sra_res", bus32.result, 32'hF800_0000);
    drive32(1'b1, 3'b010, 6'b000010, 32'd0, 32'h8000_0000, 5'd4);
    check("srl_res", bus32.result, 32'h0800_0000);
    drive32(1'b1, 3'b010, 6'b101011, 32'd1, 32'hFFFF_FFFF, 5'd0);
    check("sltu_res", bus32.result, 1);
    drive32(1'b1, 3'b010, 6'b101010, 32'd1, 32'hFFFF_FFFF, 5'd0);
    check("slt_res", bus32.result, 0);
    check("slt_zero", bus32.zero, 1);
    drive32(1'b1, 3'b010, 6'b111111, 32'd1, 32'd2, 5'd0);
    check("illegal_on", bus32.illegal, 1);
    check("illegal_res", bus32.result, 0);
    drive32(1'b0, 3'b010, 6'b111111, 32'd1, 32'd2, 5'd0);
    check("illegal_gated", bus32.illegal, 0);
    drive32(1'b1, 3'b010, 6'b100111, 32'h0F0F_0000, 32'h0000_00FF, 5'd0);
    check("nor_res", bus32.result, 32'hF0F0_FF00);
    drive32(1'b1, 3'b011, 6'd0, 32'h7FFF_FFFF, 32'd1, 5'd0);
    check("addi_ovf", bus32.overflow, 1);
    drive32(1'b1, 3'b111, 6'd0, 32'h7FFF_FFFF, 32'd1, 5'd0);
    check("addnv_ovf", bus32.overflow, 0);
    check("addnv_res", bus32.result, 32'h8000_0000);
    drive32(1'b1, 3'b110, 6'd0, 32'hFFFF_FFFF, 32'd1, 5'd0);
    check("slti_res", bus32.result, 1);
    drive32(1'b1, 3'b001, 6'd0, 32'd9, 32'd9, 5'd0);
    check("beq_zero", bus32.zero, 1);

    // mult -3 * 7 with cycle-accurate stall/busy
    drive32(1'b1, 3'b010, 6'b011000, 32'hFFFF_FFFD, 32'd7, 5'd0);
    check("mult_c0_stall", bus32.stall, 1);
    check("mult_c0_busy", bus32.md_busy, 0);
    check("mult_res0", bus32.result, 0);
    for (int c = 1; c <= 32; c++) begin
      tick();
      check($sformatf("mult_c%0d_stall", c), bus32.stall, 1);
      check($sformatf("mult_c%0d_busy", c), bus32.md_busy, 1);
    end
    tick();
    check("mult_done_stall", bus32.stall, 0);
    check("mult_done_busy", bus32.md_busy, 0);
    check("mult_hi", bus32.hi, 32'hFFFF_FFFF);
    check("mult_lo", bus32.lo, 32'hFFFF_FFEB);
    drive32(1'b1, 3'b010, 6'b010010, 32'd0, 32'd0, 5'd0);
    check("mflo_res", bus32.result, 32'hFFFF_FFEB);
    check("mflo_stall", bus32.stall, 0);
    drive32(1'b1, 3'b010, 6'b010000, 32'd0, 32'd0, 5'd0);
    check("mfhi_res", bus32.result, 32'hFFFF_FFFF);
    tick();
    check("mflo_no_restart", bus32.md_busy, 0);
    bus32.valid = 1'b0;
    tick();

    run_md(6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_hi", bus32.hi, 32'hFFFF_FFFE);
    check("multu_lo", bus32.lo, 32'h0000_0001);
    tick();

    run_md(6'b011010, 32'hFFFF_FFF9, 32'd2);
    check("div_lo", bus32.lo, 32'hFFFF_FFFD);
    check("div_hi", bus32.hi, 32'hFFFF_FFFF);
    tick();

    run_md(6'b011010, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_mneg_lo", bus32.lo, 32'h8000_0000);
    check("div_mneg_hi", bus32.hi, 0);
    tick();

    run_md(6'b011010, 32'hFFFF_FFF9, 32'd0);
    check("div0s_lo", bus32.lo, 32'hFFFF_FFFF);
    check("div0s_hi", bus32.hi, 32'hFFFF_FFF9);
    tick();

    run_md(6'b011011, 32'd9, 32'd0);
    check("divu0_lo", bus32.lo, 32'hFFFF_FFFF);
    check("divu0_hi", bus32.hi, 9);
    tick();

    // Flush in RUN cycle 10
    drive32(1'b1, 3'b010, 6'b011001, 32'd5, 32'd6, 5'd0);
    repeat (10) tick();
    check("flush_pre_busy", bus32.md_busy, 1);
    bus32.flush = 1'b1;
    tick();
    bus32.flush = 1'b0;
    bus32.valid = 1'b0;
    #1;
    check("flush_busy", bus32.md_busy, 0);
    check("flush_stall", bus32.stall, 0);
    check("flush_hi", bus32.hi, 9);
    check("flush_lo", bus32.lo, 32'hFFFF_FFFF);
    repeat (40) tick();
    check("flush_hi_late", bus32.hi, 9);

    // Reset mid-RUN
    drive32(1'b1, 3'b010, 6'b011000, 32'd3, 32'd4, 5'd0);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus32.valid = 1'b0;
    #1;
    check("rstrun_hi", bus32.hi, 0);
    check("rstrun_lo", bus32.lo, 0);
    check("rstrun_busy", bus32.md_busy, 0);

    // 16-bit build without mult/div
    bus16.valid = 1'b1; bus16.alu_op = 3'b010; bus16.funct = 6'b011000;
    bus16.a = 16'd3; bus16.b = 16'd4;
    #1;
    check("w16_mult_illegal", bus16.illegal, 1);
    check("w16_mult_stall", bus16.stall, 0);
    repeat (3) tick();
    check("w16_mult_busy", bus16.md_busy, 0);
    check("w16_mult_stall_late", bus16.stall, 0);
    bus16.funct = 6'b010010;
    #1;
    check("w16_mflo_illegal", bus16.illegal, 1);
    bus16.funct = 6'b100000; bus16.a = 16'h7FFF; bus16.b = 16'h0001;
    #1;
    check("w16_add_ovf", bus16.overflow, 1);
    check("w16_add_res", bus16.result, 16'h8000);
    check("w16_add_illegal", bus16.illegal, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
